// File: rtl/bitser_pkg.sv
// Shared constants and state encoding for the bit-serial accumulator deserializer.
package bitser_pkg;

    // Default frame width and the matching bit-index width
    localparam int W_DEF = 8;
    localparam int CNT_W = $clog2(W_DEF);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/acc_deserialize.sv
// Collects LSB-first serial bits from an accumulator into a W-bit word and
// presents it through a valid/ready register with a sticky overrun flag.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no frame in progress; next i_shift sample lands in bit 0
// ST_SHIFT | partial frame held in r_sr, r_count is the next bit index
module acc_deserialize
    import bitser_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bit,
    input  logic                 i_shift,
    input  logic                 i_abort,
    input  logic                 i_ready,
    input  logic                 i_clr_ovr,
    output logic [W-1:0]         o_data,
    output logic                 o_valid,
    output logic [$clog2(W)-1:0] o_count,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_sr;
    logic [W-1:0]  r_data;
    logic          r_valid;
    logic          r_ovr;

    state_t        w_state_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [W-1:0]  w_sr_nxt;
    logic [W-1:0]  w_word;
    logic [W-1:0]  w_data_nxt;
    logic          w_valid_nxt;
    logic          w_ovr_nxt;
    logic          w_final;

    // Next-state, datapath and handshake decode; abort wins over a same-cycle shift
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_sr_nxt         = r_sr;
        w_word           = r_sr;
        w_word[r_count]  = i_bit;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid & ~i_ready;
        w_ovr_nxt        = i_clr_ovr ? 1'b0 : r_ovr;
        w_final          = 1'b0;

        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_sr_nxt    = '0;
        end else if (i_shift) begin
            if (r_count == LAST_IDX) begin
                // Frame complete: clear the shifter so nothing leaks into the next frame
                w_final     = 1'b1;
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_sr_nxt    = '0;
            end else begin
                w_state_nxt = ST_SHIFT;
                w_count_nxt = r_count + CW'(1);
                w_sr_nxt    = w_word;
            end
        end

        if (w_final) begin
            if (!r_valid || i_ready) begin
                w_data_nxt  = w_word;
                w_valid_nxt = 1'b1;
            end else begin
                // Consumer still holds the previous word: drop the new one, set wins over clear
                w_ovr_nxt = 1'b1;
            end
        end
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_sr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sr    <= w_sr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_count   = r_count;
    assign o_overrun = r_ovr;
    assign o_busy    = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_acc_deserialize.sv
// Directed bench for acc_deserialize at W=8.
module tb_acc_deserialize;

    logic       clk;
    logic       rst_n;
    logic       i_bit;
    logic       i_shift;
    logic       i_abort;
    logic       i_ready;
    logic       i_clr_ovr;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_busy;
    logic       o_overrun;

    int total = 0;
    int bad   = 0;

    acc_deserialize #(.W(8)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_bit     (i_bit),
        .i_shift   (i_shift),
        .i_abort   (i_abort),
        .i_ready   (i_ready),
        .i_clr_ovr (i_clr_ovr),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_count   (o_count),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with i_shift high; returns 1 ns after the sampling edge
    task automatic shift_bit(input logic b);
        i_shift = 1'b1;
        i_bit   = b;
        @(posedge clk);
        #1;
        i_shift = 1'b0;
        i_bit   = 1'b0;
    endtask

    task automatic shift_bits(input logic [7:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) shift_bit(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_bit     = 1'b0;
        i_shift   = 1'b0;
        i_abort   = 1'b0;
        i_ready   = 1'b0;
        i_clr_ovr = 1'b0;
        #2;
        check("rst_data",  o_data,    0);
        check("rst_valid", o_valid,   0);
        check("rst_count", o_count,   0);
        check("rst_busy",  o_busy,    0);
        check("rst_ovr",   o_overrun, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back frame 0xA5
        i_ready = 1'b1;
        shift_bits(8'hA5, 0, 3);
        check("a5_mid_count", o_count, 4);
        check("a5_mid_busy",  o_busy,  1);
        shift_bits(8'hA5, 4, 7);
        check("a5_data",  o_data,  8'hA5);
        check("a5_valid", o_valid, 1);
        check("a5_count", o_count, 0);
        check("a5_busy",  o_busy,  0);
        idle(1);
        check("a5_consumed", o_valid, 0);

        // Same frame with a 3-cycle gap after bit index 3
        shift_bits(8'hA5, 0, 3);
        idle(3);
        check("gap_count", o_count, 4);
        check("gap_busy",  o_busy,  1);
        check("gap_valid", o_valid, 0);
        shift_bits(8'hA5, 4, 7);
        check("gap_data",  o_data,  8'hA5);
        check("gap_valid2", o_valid, 1);
        idle(1);

        // Overrun: consumer stalled across two frames
        i_ready = 1'b0;
        shift_bits(8'h3C, 0, 7);
        check("ovr_first_data", o_data,    8'h3C);
        check("ovr_first_ovr",  o_overrun, 0);
        shift_bits(8'hFF, 0, 7);
        check("ovr_keep_data",  o_data,    8'h3C);
        check("ovr_valid",      o_valid,   1);
        check("ovr_set",        o_overrun, 1);
        i_clr_ovr = 1'b1;
        idle(1);
        i_clr_ovr = 1'b0;
        check("ovr_clear",      o_overrun, 0);
        check("ovr_clr_valid",  o_valid,   1);

        // Transfer and load on the same edge
        shift_bits(8'h81, 0, 6);
        i_ready = 1'b1;
        shift_bit(1'b1);
        i_ready = 1'b0;
        check("swap_data",  o_data,    8'h81);
        check("swap_valid", o_valid,   1);
        check("swap_ovr",   o_overrun, 0);

        // Overrun set and clear in the same cycle: set wins
        shift_bits(8'h00, 0, 6);
        i_clr_ovr = 1'b1;
        shift_bit(1'b0);
        i_clr_ovr = 1'b0;
        check("setwin_ovr",  o_overrun, 1);
        check("setwin_data", o_data,    8'h81);
        i_clr_ovr = 1'b1;
        i_ready   = 1'b1;
        idle(1);
        i_clr_ovr = 1'b0;
        check("setwin_clr",  o_overrun, 0);
        check("drain_valid", o_valid,   0);

        // Abort after 5 ones, abort coincident with a shift
        shift_bits(8'hFF, 0, 4);
        i_abort = 1'b1;
        shift_bit(1'b1);
        i_abort = 1'b0;
        check("abort_count", o_count, 0);
        check("abort_busy",  o_busy,  0);
        check("abort_valid", o_valid, 0);
        shift_bits(8'h0F, 0, 7);
        check("abort_data",  o_data,  8'h0F);
        check("abort_valid2", o_valid, 1);
        idle(1);

        // Asynchronous reset mid-frame with a pending word and overrun
        i_ready = 1'b0;
        shift_bits(8'h77, 0, 7);
        shift_bits(8'h11, 0, 7);
        check("pre_rst_ovr", o_overrun, 1);
        shift_bits(8'hFF, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data",  o_data,    0);
        check("arst_valid", o_valid,   0);
        check("arst_count", o_count,   0);
        check("arst_busy",  o_busy,    0);
        check("arst_ovr",   o_overrun, 0);
        #3;
        rst_n = 1'b1;
        idle(1);
        i_ready = 1'b1;
        shift_bits(8'h5A, 0, 7);
        check("post_rst_data",  o_data,  8'h5A);
        check("post_rst_valid", o_valid, 1);
        check("post_rst_count", o_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
